// File: rtl/tinycpu_pkg.sv
// Shared constants and types for the tinycpu memory subsystem.
// The RAM geometry is common to ram and ram_loader.
package tinycpu_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    WR,
    FIN
  } ld_state_e;

endpackage

// File: rtl/ram_loader_if.sv
// Byte-stream input and RAM write port of the loader, bundled for port lists.
// Stream handshake: a byte moves on a rising edge where in_valid && in_ready are both 1;
// in_ready never depends on in_valid, and the source may drop in_valid between bytes.
interface ram_loader_if #(
  parameter int ADDR_W = tinycpu_pkg::ADDR_W,
  parameter int DATA_W = tinycpu_pkg::DATA_W
);

  logic                in_valid;
  logic [7:0]          in_data;
  logic                in_ready;
  logic                ram_load;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_d;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output ram_load,
    output ram_addr,
    output ram_d
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  ram_load,
    input  ram_addr,
    input  ram_d
  );

endinterface

// File: rtl/ram.sv
// 4K x 16 single-port RAM: synchronous write on load, asynchronous read of addr.
module ram #(
  parameter int ADDR_W = tinycpu_pkg::ADDR_W,
  parameter int DATA_W = tinycpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              load,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (load) begin
      mem[addr] <= d;
    end
  end

  assign q = mem[addr];

endmodule

// File: rtl/ram_loader.sv
// Bulk RAM preloader: packs a byte stream (high byte first) into 16-bit words
// and writes them to consecutive RAM addresses starting at base.
module ram_loader #(
  parameter int ADDR_W = tinycpu_pkg::ADDR_W,
  parameter int DATA_W = tinycpu_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base,
  input  logic [ADDR_W-1:0]      len,
  ram_loader_if.master           bus,
  output logic                   busy,
  output logic                   done,
  output tinycpu_pkg::ld_state_e dbg_state
);

  import tinycpu_pkg::*;

  ld_state_e         state;
  ld_state_e         state_nx;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] word_q;
  logic              take;

  assign take = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (len != '0) ? HI : FIN;
        end
      end
      HI: begin
        if (take) begin
          state_nx = LO;
        end
      end
      LO: begin
        if (take) begin
          state_nx = WR;
        end
      end
      WR: begin
        state_nx = (cnt_q == ADDR_W'(1)) ? FIN : HI;
      end
      FIN: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Byte assembler, word counter and address pointer; address wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      addr_q <= '0;
      word_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && (len != '0)) begin
            cnt_q  <= len;
            addr_q <= base;
          end
        end
        HI: begin
          if (take) begin
            word_q[DATA_W-1 -: BYTE_W] <= bus.in_data;
          end
        end
        LO: begin
          if (take) begin
            word_q[BYTE_W-1:0] <= bus.in_data;
          end
        end
        WR: begin
          cnt_q  <= cnt_q - ADDR_W'(1);
          addr_q <= addr_q + ADDR_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // ram_load is qualified by rst_n so a WR cycle that meets reset never commits a word.
  assign bus.in_ready = (state == HI) || (state == LO);
  assign bus.ram_load = (state == WR) && rst_n;
  assign bus.ram_addr = addr_q;
  assign bus.ram_d    = word_q;
  assign busy         = (state != IDLE);
  assign done         = (state == FIN);
  assign dbg_state    = state;

endmodule
